// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: self-sequencing SIZE x SIZE output-stationary systolic matrix multiplier
module systolic_mm_engine #(
  parameter int SIZE   = 4,
  parameter int K_DIM  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SIZE*DATA_W-1:0]    a_in,
  input  logic [SIZE*DATA_W-1:0]    b_in,
  input  logic                      signed_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_data,
  output logic [$clog2(SIZE)-1:0]   out_row,
  output logic [$clog2(SIZE)-1:0]   out_col,
  output logic                      out_last,
  output logic                      busy
);
  localparam int RW = $clog2(SIZE);
  localparam int BW = $clog2(K_DIM + 1);
  localparam int FW = $clog2(2 * SIZE);
  typedef enum logic [1:0] {LOAD, FLUSH, DRAIN} state_t;
  state_t            state_q;
  logic [BW-1:0]     beat_q;
  logic [FW-1:0]     flush_q;
  logic [RW-1:0]     row_q, col_q;
  logic              sign_q;
  logic [DATA_W-1:0] a_sk [SIZE][SIZE-1];
  logic [DATA_W-1:0] b_sk [SIZE][SIZE-1];
  logic [DATA_W-1:0] a_q  [SIZE][SIZE];
  logic [DATA_W-1:0] b_q  [SIZE][SIZE];
  logic [DATA_W-1:0] pa   [SIZE][SIZE];
  logic [DATA_W-1:0] pb   [SIZE][SIZE];
  logic [DATA_W-1:0] inj_a [SIZE];
  logic [DATA_W-1:0] inj_b [SIZE];
  logic [ACC_W-1:0]  acc_q [SIZE][SIZE];
  logic [ACC_W-1:0]  prod  [SIZE][SIZE];
  logic              take, adv, sgn, fire;

  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y, input logic s);
    logic signed [2*DATA_W-1:0] ps;
    logic [2*DATA_W-1:0]        pu;
    logic signed [ACC_W-1:0]    es;
    ps = (2*DATA_W)'($signed(x)) * (2*DATA_W)'($signed(y));
    pu = (2*DATA_W)'(x) * (2*DATA_W)'(y);
    es = ACC_W'(ps);
    return s ? es : ACC_W'(pu);
  endfunction

  assign in_ready  = state_q == LOAD;
  assign take      = in_ready & in_valid;
  assign adv       = take | (state_q == FLUSH);
  // signed_mode is live on the first beat so that beat's products use it directly
  assign sgn       = (beat_q == '0) ? signed_mode : sign_q;
  assign out_valid = state_q == DRAIN;
  assign fire      = out_valid & out_ready;
  assign out_last  = out_valid && row_q == RW'(SIZE-1) && col_q == RW'(SIZE-1);
  assign busy      = state_q != LOAD || beat_q != '0;
  assign out_data  = out_valid ? acc_q[row_q][col_q] : '0;
  assign out_row   = row_q;
  assign out_col   = col_q;

  for (genvar i = 0; i < SIZE; i++) begin : g_r
    assign inj_a[i] = (state_q == LOAD) ? a_in[i*DATA_W +: DATA_W] : '0;
    assign inj_b[i] = (state_q == LOAD) ? b_in[i*DATA_W +: DATA_W] : '0;
    for (genvar j = 0; j < SIZE; j++) begin : g_c
      if (j > 0) begin : g_ai
        assign pa[i][j] = a_q[i][j-1];
      end else if (i > 0) begin : g_as
        assign pa[i][j] = a_sk[i][i-1];
      end else begin : g_ad
        assign pa[i][j] = inj_a[i];
      end
      if (i > 0) begin : g_bi
        assign pb[i][j] = b_q[i-1][j];
      end else if (j > 0) begin : g_bs
        assign pb[i][j] = b_sk[j][j-1];
      end else begin : g_bd
        assign pb[i][j] = inj_b[j];
      end
      assign prod[i][j] = mul_ext(pa[i][j], pb[i][j], sgn);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      sign_q  <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        for (int d = 0; d < SIZE-1; d++) begin
          a_sk[i][d] <= '0;
          b_sk[i][d] <= '0;
        end
        for (int j = 0; j < SIZE; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
      end
    end else begin
      if (adv) begin
        for (int i = 0; i < SIZE; i++) begin
          a_sk[i][0] <= inj_a[i];
          b_sk[i][0] <= inj_b[i];
          for (int d = 1; d < SIZE-1; d++) begin
            a_sk[i][d] <= a_sk[i][d-1];
            b_sk[i][d] <= b_sk[i][d-1];
          end
          for (int j = 0; j < SIZE; j++) begin
            a_q[i][j]   <= pa[i][j];
            b_q[i][j]   <= pb[i][j];
            acc_q[i][j] <= acc_q[i][j] + prod[i][j];
          end
        end
      end
      if (take) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == '0) sign_q <= signed_mode;
        if (beat_q == BW'(K_DIM-1)) begin
          state_q <= FLUSH;
          flush_q <= '0;
        end
      end
      if (state_q == FLUSH) begin
        flush_q <= flush_q + 1'b1;
        if (flush_q == FW'(2*SIZE-3)) state_q <= DRAIN;
      end
      if (fire) begin
        col_q <= (col_q == RW'(SIZE-1)) ? '0 : col_q + 1'b1;
        if (col_q == RW'(SIZE-1)) row_q <= row_q + 1'b1;
        if (out_last) begin
          state_q <= LOAD;
          beat_q  <= '0;
          row_q   <= '0;
          col_q   <= '0;
          for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
              acc_q[i][j] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: directed checks of the 4x4 engine (32-bit and 16-bit accumulator instances)
module tb_systolic_mm_engine;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, signed_mode = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic        in_ready, out_valid, out_last, busy;
  logic [31:0] out_data;
  logic [1:0]  out_row, out_col;
  logic        r16_ready, v16_valid, l16_last, b16_busy;
  logic [15:0] d16_data;
  logic [1:0]  r16_row, c16_col;
  int          checks = 0, errors = 0;
  logic [31:0] acol [4], brow [4], expc [16];
  logic [15:0] exp16;
  bit          use16 = 1'b0;

  always #5 clk = ~clk;

  systolic_mm_engine #(.SIZE(4), .K_DIM(4), .DATA_W(8), .ACC_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .signed_mode(signed_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy));

  systolic_mm_engine #(.SIZE(4), .K_DIM(4), .DATA_W(8), .ACC_W(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r16_ready), .a_in(a_in), .b_in(b_in),
    .signed_mode(signed_mode), .out_valid(v16_valid), .out_ready(out_ready), .out_data(d16_data),
    .out_row(r16_row), .out_col(c16_col), .out_last(l16_last), .busy(b16_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ident;
    for (int k = 0; k < 4; k++) begin
      acol[k] = 32'h1 << (8 * k);
      brow[k] = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
    end
    for (int n = 0; n < 16; n++) expc[n] = 32'(n + 1);
  endtask

  task automatic set_fill(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    for (int k = 0; k < 4; k++) begin
      acol[k] = a;
      brow[k] = b;
    end
    for (int n = 0; n < 16; n++) expc[n] = e;
  endtask

  // signed_mode is inverted after the first beat: only the first beat's value may matter
  task automatic feed(input logic s, input bit gaps);
    chk("idle_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      if (gaps)
        for (int g = 0; g < ((k == 2) ? 5 : 1); g++) begin
          in_valid = 1'b0;
          a_in = $urandom;
          b_in = $urandom;
          tick;
          chk("gap_ready", in_ready, 1);
        end
      chk("load_ready", in_ready, 1);
      in_valid = 1'b1;
      a_in = acol[k];
      b_in = brow[k];
      signed_mode = (k == 0) ? s : ~s;
      tick;
      chk("load_busy", busy, 1);
    end
    in_valid = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
    chk("flush_ready", in_ready, 0);
  endtask

  task automatic drain(input int pct, input int lat);
    int n = 0, w = 0, cyc = 0;
    bit hs;
    while (!out_valid && w < 200) begin
      chk("flush_in_ready", in_ready, 0);
      chk("flush_busy", busy, 1);
      tick;
      w++;
    end
    if (lat >= 0) chk("latency", w, lat);
    chk("valid_seen", out_valid, 1);
    while (n < 16 && cyc < 400) begin
      out_ready = ($urandom_range(0, 99) < pct);
      chk("out_valid", out_valid, 1);
      chk("out_row", out_row, n / 4);
      chk("out_col", out_col, n % 4);
      chk("out_data", out_data, expc[n]);
      chk("out_last", out_last, n == 15);
      chk("drain_in_ready", in_ready, 0);
      chk("drain_busy", busy, 1);
      if (use16) begin
        chk("d16_valid", v16_valid, 1);
        chk("d16_row", r16_row, n / 4);
        chk("d16_col", c16_col, n % 4);
        chk("d16_data", d16_data, exp16);
        chk("d16_last", l16_last, n == 15);
      end
      hs = out_valid && out_ready;
      tick;
      cyc++;
      if (hs) n++;
    end
    out_ready = 1'b0;
    chk("handshakes", n, 16);
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_last", out_last, 0);
  endtask

  initial begin
    tick;
    tick;
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst16_in_ready", r16_ready, 1);
    chk("rst16_busy", b16_busy, 0);
    set_ident;
    feed(1'b0, 1'b0);
    drain(100, 6);
    set_fill(32'hFFFF_FFFF, 32'h0202_0202, 32'hFFFF_FFF8);
    feed(1'b1, 1'b0);
    drain(100, 6);
    set_fill(32'hFFFF_FFFF, 32'h0202_0202, 32'd2040);
    feed(1'b0, 1'b0);
    drain(100, 6);
    set_ident;
    feed(1'b0, 1'b1);
    drain(100, 6);
    set_ident;
    feed(1'b0, 1'b0);
    drain(30, -1);
    set_fill(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd260100);
    exp16 = 16'd63492;
    use16 = 1'b1;
    feed(1'b0, 1'b0);
    drain(100, 6);
    use16 = 1'b0;
    set_ident;
    feed(1'b0, 1'b0);
    tick;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", out_data, 0);
    feed(1'b0, 1'b0);
    drain(100, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
Self-sequencing, parametrised systolic matrix-multiply engine. Computes C = A x B for A of SIZE x K_DIM and B of K_DIM x SIZE. Takes one A column plus one B row per beat over a valid/ready stream and applies the diagonal input skew internally. It has a signed/unsigned mode and drains the SIZE x SIZE result as a row-major valid/ready stream. It sits between the operand fetch logic and the result write-back path, and replaces host-managed enable/select sequencing.

Parameters:
SIZE, 4, array dimension (rows of A = columns of B = PE grid edge); >=2
K_DIM, 4, inner dimension (beats per operation); >=1
DATA_W, 8, operand element width
ACC_W, 32, accumulator and result width; >= 2*DATA_W

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  engine accepts a beat
a_in  in  SIZE*DATA_W  A column k; lane i = A[i][k] at bits [i*DATA_W +: DATA_W]
b_in  in  SIZE*DATA_W  B row k; lane j = B[k][j]
signed_mode  in  1  1 = two's-complement operands; sampled on the first beat of an operation
out_valid  out  1  result element valid
out_ready  in  1  downstream accepts result
out_data  out  ACC_W  C[out_row][out_col]
out_row  out  $clog2(SIZE)  result row index
out_col  out  $clog2(SIZE)  result column index
out_last  out  1  high with the final element (row = col = SIZE-1)
busy  out  1  high in FLUSH or DRAIN, or in LOAD with beat count > 0

Behaviour:
- Reset: state=LOAD, beat count=0, drain index=0, all accumulators=0, all skew and PE pipeline registers=0. Outputs: in_ready=1, out_valid=0, out_last=0, busy=0, out_data/out_row/out_col=0.
- An "advance" is one cycle in which the skew chains and PE pipeline shift and every PE does acc += a*b. PEs hold state when there is no advance.
- Skew: lane i of a_in passes through i advance-registers before PE(i,0). Lane j of b_in passes through j advance-registers before PE(0,j). PE(i,j) registers its a to PE(i,j+1) and its b to PE(i+1,j) on each advance. Beat n therefore contributes A[i][n]*B[n][j] to PE(i,j) on advance n+i+j.
- Product: 2*DATA_W bits, sign-extended (signed_mode latched 1) or zero-extended to ACC_W. Accumulation wraps modulo 2^ACC_W; no saturation or flag.
- LOAD: in_ready=1. Each in_valid&in_ready is one advance with that beat injected, and the beat count increments. There is no advance on cycles with in_valid=0 (stall). On the K_DIM-th accepted beat: go to FLUSH with the flush counter cleared.
- FLUSH: in_ready=0. Zeros are injected and there is an advance every cycle for exactly 2*SIZE-2 cycles, then go to DRAIN. With SIZE=2-1 edge cases: if 2*SIZE-2 = 0 (not permitted, SIZE>=2), FLUSH would be skipped.
- DRAIN: in_ready=0, out_valid=1.
  - out_data = acc of PE(idx/SIZE, idx%SIZE); row and col decoded from idx.
  - out_data, out_row and out_col hold stable while out_ready=0.
  - idx increments on each out_valid&out_ready.
  - out_last=1 when idx = SIZE*SIZE-1.
  - On the handshake of the last element: clear all accumulators, beat count and idx, and go to LOAD. out_valid=0 and in_ready=1 on the next cycle.
- in_valid is ignored outside LOAD. Inputs do not need to be stable while in_ready=0.
- Latency, back-to-back beats, no backpressure: beats accepted on cycles 0..K_DIM-1; FLUSH on cycles K_DIM..K_DIM+2*SIZE-3; out_valid first high on cycle K_DIM+2*SIZE-2.
- reset asserted in any state overrides everything; the next operation starts clean with no residual accumulation.

Test Plan:
1. SIZE=4, K_DIM=4, DATA_W=8, ACC_W=32, unsigned. A=I, B[k][j]=4k+j+1, beats back-to-back from cycle 0 -> out_valid first high at cycle 10; outputs 1..16 in order with row/col 0,0 .. 3,3; out_last only on 16; next cycle in_ready=1.
2. A all 0xFF, B all 0x02. signed_mode=1 -> all 16 outputs 0xFFFFFFF8 (-8). Repeat with signed_mode=0 -> all outputs 2040.
3. Test 1 operands with in_valid low on alternate cycles, plus a 5-cycle gap mid-operation -> identical 16 results; in_ready stays 1 throughout LOAD.
4. Test 1 with out_ready random at 30% -> out_data/out_row/out_col stable while stalled; exactly 16 handshakes; in_ready=0 and busy=1 until the final handshake.
5. ACC_W=16, unsigned, A and B all 0xFF -> every output 63492 (260100 mod 65536).
6. Assert reset in FLUSH cycle 3, then run test 1 -> same 16 results as test 1; out_valid=0 and in_ready=1 on the cycle after reset.
